// File: rtl/vid_sched_pkg.sv
// rtl/vid_sched_pkg.sv - shared types and helpers for the line buffer scheduler
package vid_sched_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        WRITING = 2'd1,
        FULL    = 2'd2,
        READING = 2'd3
    } buf_state_t;

    typedef logic [0:0] wr_fsm_t;
    typedef logic [0:0] rd_fsm_t;

    localparam wr_fsm_t W_IDLE   = 1'b0;
    localparam wr_fsm_t W_ACTIVE = 1'b1;
    localparam rd_fsm_t R_IDLE   = 1'b0;
    localparam rd_fsm_t R_ACTIVE = 1'b1;

    // Advance a ring index by step, wrapping at num_bufs.
    function automatic int ring_inc(input int idx, input int step, input int num_bufs);
        return (idx + step) % num_bufs;
    endfunction

endpackage

// File: rtl/line_buf_scheduler_if.sv
// rtl/line_buf_scheduler_if.sv - writer/reader handshake bundle for the line buffer scheduler
interface line_buf_scheduler_if #(
    parameter int NUM_BUFS = 2
);
    localparam int BUF_W = $clog2(NUM_BUFS);
    localparam int OCC_W = $clog2(NUM_BUFS + 1);

    logic             flush;
    logic             wr_req;
    logic             wr_gnt;
    logic [BUF_W-1:0] wr_sel;
    logic             wr_beat;
    logic             rd_req;
    logic             rd_pair;
    logic             rd_keep;
    logic             rd_gnt;
    logic [BUF_W-1:0] rd_sel_a;
    logic [BUF_W-1:0] rd_sel_b;
    logic             rd_beat;
    logic [OCC_W-1:0] occupancy;
    logic             field_done;
    logic             err_beat;

    modport master (
        output flush, wr_req, wr_beat, rd_req, rd_pair, rd_keep, rd_beat,
        input  wr_gnt, wr_sel, rd_gnt, rd_sel_a, rd_sel_b, occupancy, field_done, err_beat
    );

    modport slave (
        input  flush, wr_req, wr_beat, rd_req, rd_pair, rd_keep, rd_beat,
        output wr_gnt, wr_sel, rd_gnt, rd_sel_a, rd_sel_b, occupancy, field_done, err_beat
    );
endinterface

// File: rtl/line_beat_counter.sv
// rtl/line_beat_counter.sv - per-line pixel beat counter with last-beat flag
module line_beat_counter #(
    parameter int WIDTH = 640,
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             beat_i,
    output logic             last_o,
    output logic [CNT_W-1:0] count_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign last_o  = (cnt_q == CNT_W'(WIDTH - 1));
    assign count_o = cnt_q;

    // Count beats, wrapping to zero on the last beat of a line.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)
            cnt_d = '0;
        else if (beat_i)
            cnt_d = last_o ? '0 : cnt_q + CNT_W'(1);
    end

    // Counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
endmodule

// File: rtl/line_buf_scheduler.sv
// rtl/line_buf_scheduler.sv - ring-ordered line buffer grants for writer and reader
module line_buf_scheduler
    import vid_sched_pkg::*;
#(
    parameter int NUM_BUFS        = 2,
    parameter int WIDTH           = 640,
    parameter int LINES_PER_FIELD = 240
) (
    input  logic                  clock,
    input  logic                  reset,
    line_buf_scheduler_if.slave   bus
);
    localparam int BUF_W  = $clog2(NUM_BUFS);
    localparam int OCC_W  = $clog2(NUM_BUFS + 1);
    localparam int CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int LCNT_W = (LINES_PER_FIELD > 1) ? $clog2(LINES_PER_FIELD) : 1;

    buf_state_t       bst_q [NUM_BUFS];
    buf_state_t       bst_d [NUM_BUFS];
    wr_fsm_t          wstate_q, wstate_d;
    rd_fsm_t          rstate_q, rstate_d;
    logic [BUF_W-1:0] wp_q, wp_d, rp_q, rp_d, rp_nx;
    logic             wr_gnt_q, wr_gnt_d, rd_gnt_q, rd_gnt_d;
    logic [BUF_W-1:0] wr_sel_q, wr_sel_d, rd_sel_a_q, rd_sel_a_d, rd_sel_b_q, rd_sel_b_d;
    logic             pair_q, pair_d, keep_q, keep_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [LCNT_W-1:0] lcnt_q, lcnt_d;
    logic             field_done_q, field_done_d, err_q, err_d;
    logic             w_beat, r_beat, w_last, r_last, w_done, r_done;
    logic [CNT_W-1:0] wcnt_unused, rcnt_unused;

    // Beats only count while the matching side holds a grant; flush discards them.
    assign w_beat = bus.wr_beat && (wstate_q == W_ACTIVE) && !bus.flush;
    assign r_beat = bus.rd_beat && (rstate_q == R_ACTIVE) && !bus.flush;
    assign w_done = w_beat && w_last;
    assign r_done = r_beat && r_last;
    assign rp_nx  = BUF_W'(ring_inc(int'(rp_q), 1, NUM_BUFS));

    line_beat_counter #(.WIDTH(WIDTH)) u_wcnt (
        .clock(clock), .reset(reset), .clear_i(bus.flush), .beat_i(w_beat),
        .last_o(w_last), .count_o(wcnt_unused)
    );

    line_beat_counter #(.WIDTH(WIDTH)) u_rcnt (
        .clock(clock), .reset(reset), .clear_i(bus.flush), .beat_i(r_beat),
        .last_o(r_last), .count_o(rcnt_unused)
    );

    // Next-state for both FSMs; they always touch disjoint buffers, flush overrides all.
    always_comb begin
        bst_d        = bst_q;
        wstate_d     = wstate_q;
        rstate_d     = rstate_q;
        wp_d         = wp_q;
        rp_d         = rp_q;
        wr_gnt_d     = wr_gnt_q;
        rd_gnt_d     = rd_gnt_q;
        wr_sel_d     = wr_sel_q;
        rd_sel_a_d   = rd_sel_a_q;
        rd_sel_b_d   = rd_sel_b_q;
        pair_d       = pair_q;
        keep_d       = keep_q;
        lcnt_d       = lcnt_q;
        field_done_d = 1'b0;
        err_d        = !bus.flush && ((bus.wr_beat && wstate_q == W_IDLE) ||
                                      (bus.rd_beat && rstate_q == R_IDLE));

        if (wstate_q == W_IDLE) begin
            if (bus.wr_req && bst_q[wp_q] == EMPTY) begin
                wstate_d    = W_ACTIVE;
                wr_gnt_d    = 1'b1;
                wr_sel_d    = wp_q;
                bst_d[wp_q] = WRITING;
            end
        end else if (w_done) begin
            bst_d[wr_sel_q] = FULL;
            wp_d            = BUF_W'(ring_inc(int'(wp_q), 1, NUM_BUFS));
            wr_gnt_d        = 1'b0;
            wstate_d        = W_IDLE;
            if (lcnt_q == LCNT_W'(LINES_PER_FIELD - 1)) begin
                lcnt_d       = '0;
                field_done_d = 1'b1;
            end else begin
                lcnt_d = lcnt_q + LCNT_W'(1);
            end
        end

        if (rstate_q == R_IDLE) begin
            if (bus.rd_req && bst_q[rp_q] == FULL && (!bus.rd_pair || bst_q[rp_nx] == FULL)) begin
                rstate_d    = R_ACTIVE;
                rd_gnt_d    = 1'b1;
                rd_sel_a_d  = rp_q;
                rd_sel_b_d  = rp_nx;
                pair_d      = bus.rd_pair;
                keep_d      = bus.rd_keep;
                bst_d[rp_q] = READING;
                if (bus.rd_pair)
                    bst_d[rp_nx] = READING;
            end
        end else if (r_done) begin
            rstate_d = R_IDLE;
            rd_gnt_d = 1'b0;
            if (pair_q) begin
                bst_d[rd_sel_a_q] = EMPTY;
                if (keep_q) begin
                    bst_d[rd_sel_b_q] = FULL;
                    rp_d              = rd_sel_b_q;
                end else begin
                    bst_d[rd_sel_b_q] = EMPTY;
                    rp_d              = BUF_W'(ring_inc(int'(rd_sel_a_q), 2, NUM_BUFS));
                end
            end else if (keep_q) begin
                bst_d[rd_sel_a_q] = FULL;
            end else begin
                bst_d[rd_sel_a_q] = EMPTY;
                rp_d              = rd_sel_b_q;
            end
        end

        if (bus.flush) begin
            for (int i = 0; i < NUM_BUFS; i++)
                bst_d[i] = EMPTY;
            wstate_d = W_IDLE;
            rstate_d = R_IDLE;
            wp_d = '0; rp_d = '0;
            wr_gnt_d = 1'b0; rd_gnt_d = 1'b0;
            wr_sel_d = '0; rd_sel_a_d = '0; rd_sel_b_d = '0;
            pair_d = 1'b0; keep_d = 1'b0;
            lcnt_d = '0;
            field_done_d = 1'b0;
        end

        occ_d = '0;
        for (int i = 0; i < NUM_BUFS; i++)
            if (bst_d[i] == FULL)
                occ_d = occ_d + OCC_W'(1);
    end

    // State registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_BUFS; i++)
                bst_q[i] <= EMPTY;
            wstate_q <= W_IDLE;      rstate_q <= R_IDLE;
            wp_q <= '0;              rp_q <= '0;
            wr_gnt_q <= 1'b0;        rd_gnt_q <= 1'b0;
            wr_sel_q <= '0;          rd_sel_a_q <= '0;       rd_sel_b_q <= '0;
            pair_q <= 1'b0;          keep_q <= 1'b0;
            occ_q <= '0;             lcnt_q <= '0;
            field_done_q <= 1'b0;    err_q <= 1'b0;
        end else begin
            bst_q <= bst_d;
            wstate_q <= wstate_d;    rstate_q <= rstate_d;
            wp_q <= wp_d;            rp_q <= rp_d;
            wr_gnt_q <= wr_gnt_d;    rd_gnt_q <= rd_gnt_d;
            wr_sel_q <= wr_sel_d;    rd_sel_a_q <= rd_sel_a_d; rd_sel_b_q <= rd_sel_b_d;
            pair_q <= pair_d;        keep_q <= keep_d;
            occ_q <= occ_d;          lcnt_q <= lcnt_d;
            field_done_q <= field_done_d; err_q <= err_d;
        end
    end

    assign bus.wr_gnt     = wr_gnt_q;
    assign bus.wr_sel     = wr_sel_q;
    assign bus.rd_gnt     = rd_gnt_q;
    assign bus.rd_sel_a   = rd_sel_a_q;
    assign bus.rd_sel_b   = rd_sel_b_q;
    assign bus.occupancy  = occ_q;
    assign bus.field_done = field_done_q;
    assign bus.err_beat   = err_q;
endmodule

// File: tb/tb_line_buf_scheduler.sv
// tb/tb_line_buf_scheduler.sv - directed self-checking bench for line_buf_scheduler
module tb_line_buf_scheduler;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    line_buf_scheduler_if #(.NUM_BUFS(2)) bus ();

    line_buf_scheduler #(.NUM_BUFS(2), .WIDTH(4), .LINES_PER_FIELD(3)) dut (
        .clock(clk), .reset(rst_n), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_wr_gnt(output bit ok);
        for (int i = 0; i < 20 && !bus.wr_gnt; i++) tick();
        ok = bus.wr_gnt;
    endtask

    task automatic wait_rd_gnt(output bit ok);
        for (int i = 0; i < 20 && !bus.rd_gnt; i++) tick();
        ok = bus.rd_gnt;
    endtask

    task automatic write_line(output bit ok);
        bus.wr_req = 1'b1;
        wait_wr_gnt(ok);
        bus.wr_req = 1'b0;
        if (ok) begin
            for (int i = 0; i < 4; i++) begin bus.wr_beat = 1'b1; tick(); end
            bus.wr_beat = 1'b0;
        end
    endtask

    task automatic read_line(input bit pair, input bit keep, output bit ok);
        bus.rd_req = 1'b1; bus.rd_pair = pair; bus.rd_keep = keep;
        wait_rd_gnt(ok);
        bus.rd_req = 1'b0;
        if (ok) begin
            for (int i = 0; i < 4; i++) begin bus.rd_beat = 1'b1; tick(); end
            bus.rd_beat = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.flush = 0; bus.wr_req = 0; bus.wr_beat = 0;
        bus.rd_req = 0; bus.rd_pair = 0; bus.rd_keep = 0; bus.rd_beat = 0;
        tick(); tick();
        n_tests++; if (bus.wr_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_wr_gnt got=%0d exp=0", bus.wr_gnt); end
        n_tests++; if (bus.rd_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_rd_gnt got=%0d exp=0", bus.rd_gnt); end
        n_tests++; if (bus.wr_sel !== 1'b0) begin n_fail++; $display("FAIL rst_wr_sel got=%0d exp=0", bus.wr_sel); end
        n_tests++; if (bus.rd_sel_a !== 1'b0 || bus.rd_sel_b !== 1'b0) begin n_fail++; $display("FAIL rst_rd_sel got=%0d/%0d exp=0/0", bus.rd_sel_a, bus.rd_sel_b); end
        n_tests++; if (bus.occupancy !== 2'd0) begin n_fail++; $display("FAIL rst_occ got=%0d exp=0", bus.occupancy); end
        n_tests++; if (bus.field_done !== 1'b0 || bus.err_beat !== 1'b0) begin n_fail++; $display("FAIL rst_pulses got=%0d/%0d exp=0/0", bus.field_done, bus.err_beat); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_write();
        bus.wr_req = 1'b1;
        tick();
        n_tests++; if (bus.wr_gnt !== 1'b1 || bus.wr_sel !== 1'b0) begin n_fail++; $display("FAIL t1_gnt0 got=%0d sel=%0d exp=1 sel=0", bus.wr_gnt, bus.wr_sel); end
        for (int i = 0; i < 4; i++) begin bus.wr_beat = 1'b1; tick(); end
        bus.wr_beat = 1'b0;
        n_tests++; if (bus.wr_gnt !== 1'b0) begin n_fail++; $display("FAIL t1_gnt_drop got=%0d exp=0", bus.wr_gnt); end
        n_tests++; if (bus.occupancy !== 2'd1) begin n_fail++; $display("FAIL t1_occ got=%0d exp=1", bus.occupancy); end
        tick();
        n_tests++; if (bus.wr_gnt !== 1'b1 || bus.wr_sel !== 1'b1) begin n_fail++; $display("FAIL t1_gnt1 got=%0d sel=%0d exp=1 sel=1", bus.wr_gnt, bus.wr_sel); end
        bus.wr_req = 1'b0;
        for (int i = 0; i < 4; i++) begin bus.wr_beat = 1'b1; tick(); end
        bus.wr_beat = 1'b0;
        n_tests++; if (bus.occupancy !== 2'd2) begin n_fail++; $display("FAIL t1_occ2 got=%0d exp=2", bus.occupancy); end
    endtask

    task automatic test_pair_keep();
        bus.rd_req = 1'b1; bus.rd_pair = 1'b1; bus.rd_keep = 1'b1;
        tick();
        bus.rd_req = 1'b0;
        n_tests++; if (bus.rd_gnt !== 1'b1 || bus.rd_sel_a !== 1'b0 || bus.rd_sel_b !== 1'b1) begin n_fail++; $display("FAIL t2_gnt got=%0d a=%0d b=%0d exp=1 a=0 b=1", bus.rd_gnt, bus.rd_sel_a, bus.rd_sel_b); end
        n_tests++; if (bus.occupancy !== 2'd0) begin n_fail++; $display("FAIL t2_occ_rd got=%0d exp=0", bus.occupancy); end
        for (int i = 0; i < 4; i++) begin bus.rd_beat = 1'b1; tick(); end
        bus.rd_beat = 1'b0;
        n_tests++; if (bus.rd_gnt !== 1'b0) begin n_fail++; $display("FAIL t2_gnt_drop got=%0d exp=0", bus.rd_gnt); end
        n_tests++; if (bus.occupancy !== 2'd1) begin n_fail++; $display("FAIL t2_occ got=%0d exp=1", bus.occupancy); end
        bus.wr_req = 1'b1;
        tick();
        bus.wr_req = 1'b0;
        n_tests++; if (bus.wr_gnt !== 1'b1 || bus.wr_sel !== 1'b0) begin n_fail++; $display("FAIL t2_wr_gnt got=%0d sel=%0d exp=1 sel=0", bus.wr_gnt, bus.wr_sel); end
        for (int i = 0; i < 4; i++) begin bus.wr_beat = 1'b1; tick(); end
        bus.wr_beat = 1'b0;
    endtask

    task automatic test_ring_full();
        bit ok;
        pulse_reset();
        write_line(ok);
        write_line(ok);
        n_tests++; if (bus.occupancy !== 2'd2) begin n_fail++; $display("FAIL t3_occ2 got=%0d exp=2", bus.occupancy); end
        bus.wr_req = 1'b1;
        tick(); tick(); tick();
        n_tests++; if (bus.wr_gnt !== 1'b0) begin n_fail++; $display("FAIL t3_full_gnt got=%0d exp=0", bus.wr_gnt); end
        bus.rd_req = 1'b1; bus.rd_pair = 1'b0; bus.rd_keep = 1'b0;
        wait_rd_gnt(ok);
        bus.rd_req = 1'b0;
        n_tests++; if (ok !== 1'b1 || bus.rd_sel_a !== 1'b0) begin n_fail++; $display("FAIL t3_rd_gnt got=%0d a=%0d exp=1 a=0", ok, bus.rd_sel_a); end
        for (int i = 0; i < 4; i++) begin bus.rd_beat = 1'b1; tick(); end
        bus.rd_beat = 1'b0;
        n_tests++; if (bus.wr_gnt !== 1'b0 || bus.rd_gnt !== 1'b0) begin n_fail++; $display("FAIL t3_gap got=%0d/%0d exp=0/0", bus.wr_gnt, bus.rd_gnt); end
        n_tests++; if (bus.occupancy !== 2'd1) begin n_fail++; $display("FAIL t3_occ1 got=%0d exp=1", bus.occupancy); end
        tick();
        bus.wr_req = 1'b0;
        n_tests++; if (bus.wr_gnt !== 1'b1 || bus.wr_sel !== 1'b0) begin n_fail++; $display("FAIL t3_regnt got=%0d sel=%0d exp=1 sel=0", bus.wr_gnt, bus.wr_sel); end
    endtask

    task automatic test_field_done();
        bit ok;
        pulse_reset();
        write_line(ok);
        n_tests++; if (bus.field_done !== 1'b0) begin n_fail++; $display("FAIL t4_fd_l1 got=%0d exp=0", bus.field_done); end
        write_line(ok);
        n_tests++; if (bus.field_done !== 1'b0) begin n_fail++; $display("FAIL t4_fd_l2 got=%0d exp=0", bus.field_done); end
        read_line(1'b0, 1'b0, ok);
        write_line(ok);
        n_tests++; if (bus.field_done !== 1'b1) begin n_fail++; $display("FAIL t4_fd_l3 got=%0d exp=1", bus.field_done); end
        tick();
        n_tests++; if (bus.field_done !== 1'b0) begin n_fail++; $display("FAIL t4_fd_once got=%0d exp=0", bus.field_done); end
        for (int k = 0; k < 3; k++) begin
            read_line(1'b0, 1'b0, ok);
            write_line(ok);
            n_tests++; if (bus.field_done !== (k == 2)) begin n_fail++; $display("FAIL t4_wrap_%0d got=%0d exp=%0d", k, bus.field_done, (k == 2)); end
        end
    endtask

    task automatic test_err_flush();
        bit ok;
        pulse_reset();
        bus.wr_beat = 1'b1;
        tick();
        bus.wr_beat = 1'b0;
        n_tests++; if (bus.err_beat !== 1'b1) begin n_fail++; $display("FAIL t5_err_wr got=%0d exp=1", bus.err_beat); end
        tick();
        n_tests++; if (bus.err_beat !== 1'b0) begin n_fail++; $display("FAIL t5_err_pulse got=%0d exp=0", bus.err_beat); end
        bus.rd_beat = 1'b1;
        tick();
        bus.rd_beat = 1'b0;
        n_tests++; if (bus.err_beat !== 1'b1) begin n_fail++; $display("FAIL t5_err_rd got=%0d exp=1", bus.err_beat); end
        write_line(ok);
        write_line(ok);
        bus.rd_req = 1'b1; bus.rd_pair = 1'b0; bus.rd_keep = 1'b0;
        wait_rd_gnt(ok);
        bus.rd_req = 1'b0;
        n_tests++; if (ok !== 1'b1 || bus.occupancy !== 2'd1) begin n_fail++; $display("FAIL t5_pre got=%0d occ=%0d exp=1 occ=1", ok, bus.occupancy); end
        for (int i = 0; i < 2; i++) begin bus.rd_beat = 1'b1; tick(); end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0; bus.rd_beat = 1'b0;
        n_tests++; if (bus.rd_gnt !== 1'b0 || bus.occupancy !== 2'd0) begin n_fail++; $display("FAIL t5_flush got=%0d occ=%0d exp=0 occ=0", bus.rd_gnt, bus.occupancy); end
        n_tests++; if (bus.err_beat !== 1'b0) begin n_fail++; $display("FAIL t5_flush_err got=%0d exp=0", bus.err_beat); end
        bus.wr_req = 1'b1;
        tick();
        bus.wr_req = 1'b0;
        n_tests++; if (bus.wr_gnt !== 1'b1 || bus.wr_sel !== 1'b0 || bus.err_beat !== 1'b0) begin n_fail++; $display("FAIL t5_post got=%0d sel=%0d err=%0d exp=1 sel=0 err=0", bus.wr_gnt, bus.wr_sel, bus.err_beat); end
    endtask

    task automatic test_async_reset();
        bit ok;
        pulse_reset();
        bus.wr_req = 1'b1;
        wait_wr_gnt(ok);
        bus.wr_req = 1'b0;
        for (int i = 0; i < 2; i++) begin bus.wr_beat = 1'b1; tick(); end
        bus.wr_beat = 1'b0;
        rst_n = 1'b0;
        #1;
        n_tests++; if (bus.wr_gnt !== 1'b0) begin n_fail++; $display("FAIL t6_async got=%0d exp=0", bus.wr_gnt); end
        tick();
        rst_n = 1'b1;
        bus.wr_req = 1'b1;
        wait_wr_gnt(ok);
        bus.wr_req = 1'b0;
        n_tests++; if (ok !== 1'b1 || bus.wr_sel !== 1'b0) begin n_fail++; $display("FAIL t6_regnt got=%0d sel=%0d exp=1 sel=0", ok, bus.wr_sel); end
        for (int i = 0; i < 3; i++) begin bus.wr_beat = 1'b1; tick(); end
        n_tests++; if (bus.wr_gnt !== 1'b1 || bus.occupancy !== 2'd0) begin n_fail++; $display("FAIL t6_partial got=%0d occ=%0d exp=1 occ=0", bus.wr_gnt, bus.occupancy); end
        tick();
        bus.wr_beat = 1'b0;
        n_tests++; if (bus.wr_gnt !== 1'b0 || bus.occupancy !== 2'd1) begin n_fail++; $display("FAIL t6_full got=%0d occ=%0d exp=0 occ=1", bus.wr_gnt, bus.occupancy); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_basic_write();
        test_pair_keep();
        test_ring_full();
        test_field_done();
        test_err_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/line_buf_scheduler.md
Name: line_buf_scheduler

Overview:
- Sequences a ring of single-line video buffers between one line writer (the Avalon-ST sink side) and one line reader (the source side) in the deinterlacer datapath.
- Grants buffers to the writer in ring order and tracks each buffer's state.
- Grants the reader either one full line (pass-through) or two consecutive full lines (interpolation), then frees or retains buffers when the line completes.
- Counts written lines per field, so the sink FSM no longer hand-tracks buffer ownership.

Parameters:
- NUM_BUFS, 2: number of line buffers in the ring. Legal range 2..4.
- WIDTH, 640: pixels per line, i.e. beats per buffer fill or drain.
- LINES_PER_FIELD, 240: lines per field. Used for the field-done pulse.
- BUF_W, $clog2(NUM_BUFS): width of the buffer index (localparam).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- flush  in  1  synchronous field flush pulse.
- wr_req  in  1  writer wants a buffer (level).
- wr_gnt  out  1  writer owns buffer wr_sel.
- wr_sel  out  BUF_W  buffer index to write.
- wr_beat  in  1  one pixel written this cycle.
- rd_req  in  1  reader wants line(s) (level).
- rd_pair  in  1  sampled with rd_req: 1 = needs two lines, 0 = one line.
- rd_keep  in  1  sampled with rd_req: 1 = keep the newest granted buffer FULL after drain.
- rd_gnt  out  1  reader owns the granted buffer(s).
- rd_sel_a  out  BUF_W  older (or only) buffer.
- rd_sel_b  out  BUF_W  newer buffer; valid only in pair mode.
- rd_beat  in  1  one pixel read this cycle.
- occupancy  out  $clog2(NUM_BUFS+1)  count of FULL buffers.
- field_done  out  1  one-cycle pulse on the LINES_PER_FIELD-th completed write.
- err_beat  out  1  one-cycle pulse on wr_beat or rd_beat with no grant.

Behaviour:
- **Buffer state:** per-buffer state EMPTY / WRITING / FULL / READING. Write pointer wp and read pointer rp advance modulo NUM_BUFS, so read order equals write order.
- **Reset:**
  - Outputs: wr_gnt=0, rd_gnt=0, wr_sel=0, rd_sel_a=0, rd_sel_b=0, occupancy=0, field_done=0, err_beat=0.
  - Internal: all buffers EMPTY, wp=rp=0, pixel counters 0, line counter 0, both FSMs IDLE.
- **Write FSM (W_IDLE, W_ACTIVE):**
  - W_IDLE→W_ACTIVE when wr_req=1 and buf[wp]==EMPTY. wr_gnt and wr_sel=wp are registered, so they appear 1 cycle after the condition. buf[wp] becomes WRITING.
  - In W_ACTIVE each wr_beat increments wcnt.
  - On the beat where wcnt==WIDTH-1: buf becomes FULL, wp advances, wcnt clears, wr_gnt drops on the next edge, FSM returns to W_IDLE.
  - A back-to-back grant needs one more idle cycle: minimum 1-cycle gap between lines.
  - If no EMPTY buffer is available, the writer waits; there is no error.
- **Read FSM (R_IDLE, R_ACTIVE):**
  - Single mode (rd_pair=0) needs buf[rp]==FULL.
  - Pair mode (rd_pair=1) needs buf[rp] and buf[rp+1] both FULL.
  - When the requirement is met, rd_gnt is registered high 1 cycle later. rd_sel_a=rp and rd_sel_b=rp+1 (mod NUM_BUFS). Granted buffers become READING.
  - rd_pair and rd_keep are latched at grant.
  - Each rd_beat increments rcnt. On the beat where rcnt==WIDTH-1, rd_gnt drops the next edge.
  - Release on completion:
    - Pair, keep=1: buf a→EMPTY, buf b→FULL, rp+=1.
    - Pair, keep=0: both→EMPTY, rp+=2.
    - Single, keep=1: buf a→FULL, rp unchanged.
    - Single, keep=0: buf a→EMPTY, rp+=1.
- **Same-cycle events:**
  - Write completion and read availability in the same cycle: the read FSM sees the registered FULL state and grants 1 cycle later. There is no combinational bypass.
  - Write and read grants may both assert in the same cycle. They always target different buffers.
  - A buffer freed by a read completion is grantable to the writer on the following cycle.
- **occupancy:** registered count of FULL buffers; READING and WRITING buffers are excluded.
- **Line counter:** lcnt increments on each write completion. When lcnt==LINES_PER_FIELD-1 at completion, field_done pulses and lcnt wraps to 0.
- **flush:** highest priority. On the next edge it returns every buffer, pointer, counter and FSM to reset values and deasserts the grants. Beats in the flush cycle are ignored and do not raise err_beat.
- **Asynchronous reset mid-line:** immediate return to reset state; no partial-line state survives.
- **err_beat:** pulses for any wr_beat while in W_IDLE or rd_beat while in R_IDLE. The beat is otherwise ignored.

Decomposition:
- Package vid_sched_pkg holds:
  - typedef buf_state_t {EMPTY, WRITING, FULL, READING}
  - typedef wr_fsm_t and rd_fsm_t
  - function ring_inc(idx, step, NUM_BUFS)
- One sub-module, line_beat_counter (WIDTH param; inputs clear and beat; outputs last flag and count). It is instantiated twice, once for wcnt and once for rcnt.

Test Plan:
All scenarios use WIDTH=4, NUM_BUFS=2, LINES_PER_FIELD=3.
1. Basic write. Reset released, wr_req=1, 4 wr_beats → wr_gnt high 1 cycle after wr_req with wr_sel=0; wr_gnt low after the 4th beat; occupancy=1; second grant with wr_sel=1 after a 1-cycle gap.
2. Pair read with keep. Fill both buffers, rd_req=1 rd_pair=1 rd_keep=1, 4 rd_beats → rd_gnt with sel_a=0, sel_b=1. Afterwards buf0 EMPTY, buf1 FULL, occupancy=1, and the next wr_gnt has wr_sel=0.
3. Ring full. wr_req held after 2 lines with no reads → wr_gnt stays 0. A single read with keep=0 completes → wr_gnt asserts 2 cycles later with wr_sel=0.
4. Field done. 3 write completions (interleaved reads keep the ring free) → field_done pulses exactly once, in the cycle after the 3rd completion; line count wraps to 0.
5. Error and flush. wr_beat with no grant → err_beat=1 for 1 cycle. Then flush mid-read (rcnt=2) → rd_gnt=0, occupancy=0 next cycle, no err_beat.
6. Async reset mid-write. reset=0 after 2 beats → wr_gnt=0 immediately. After release, the new grant has wr_sel=0 and the line needs the full 4 beats to complete.
